ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
AHB-Lite slave (responder) backed by an internal word-organised memory array. It is the memory-side end of the instruction-fetch master interface: it serves NONSEQ/SEQ fetch beats, including INCR/WRAP bursts, treating each beat independently. It also accepts byte/half/word writes for preload and debug. Wait states are configurable; out-of-range, misaligned and oversize transfers receive the standard two-cycle ERROR response.

Parameters:
MEM_BYTES, 4096, memory size in bytes; power of two, at least 4; word count = MEM_BYTES/4
WAIT_STATES, 0, extra HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15

Ports:
HCLK  input  1  clock; all state updates on the rising edge
HRESET  input  1  synchronous reset, active-high
HSEL  input  1  slave select from the address decoder
HADDR  input  32  transfer address, byte granular
HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  input  1  1 = write, 0 = read
HSIZE  input  3  0 = byte, 1 = half-word, 2 = word; values of 3 and above are illegal
HBURST  input  3  burst type; accepted and ignored (beats handled individually)
HWDATA  input  32  write data, valid in the data phase
HREADY  input  1  bus-wide ready from the response multiplexer
HRDATA  output  32  read data
HREADYOUT  output  1  this slave's ready
HRESP  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (HRESET=1 at a rising edge): HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter=0, pending transfer discarded. Memory contents are not cleared.
- Address-phase accept: the address phase is accepted when HSEL & HREADY & HTRANS[1] are all 1.
- On accept, register address, HWRITE and HSIZE, then classify the transfer.
- Classification, ERROR if any of the following:
  - HADDR >= MEM_BYTES
  - HSIZE > 2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0] != 0
- All other accepted transfers are OKAY.
- No accept: HSEL=0, HTRANS IDLE/BUSY, or HREADY=0 means no transfer. If the slave is not in a data phase it stays in IDLE with HREADYOUT=1, HRESP=0.
- State machine:
  - IDLE: on accept of an OKAY transfer, go to WAIT if WAIT_STATES>0, else DATA. On accept of an ERROR transfer, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter loads WAIT_STATES-1 on entry and decrements each cycle. At 0, go to DATA.
  - DATA: HREADYOUT=1, HRESP=0. The transfer completes this cycle. A new accept in the same cycle (pipelined next address phase) goes to WAIT, DATA or ERR1 as for IDLE; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept in this cycle is handled as in DATA. The master may instead drive IDLE to cancel the next transfer.
- With WAIT_STATES=0, back-to-back beats complete one per cycle.
- Read: HRDATA presents the full aligned word mem[addr_q[log2(MEM_BYTES)-1:2]] in the DATA cycle, little-endian lanes, so the master selects the byte or half-word.
  - The array read is combinational from the registered address.
  - HRDATA holds its last value in all other cycles, including after writes and ERRORs.
- Write: in the DATA cycle, HWDATA lanes selected by size and addr_q[1:0] are written at the clock edge.
  - Byte: one lane.
  - Half-word: lanes {1,0} or {3,2}.
  - Word: all four lanes.
  - Unselected bytes are unchanged.
- ERROR transfers never read or write memory and never update HRDATA.
- Read-after-write: a read accepted during the write's DATA cycle returns the newly written data.
- Reset mid-WAIT, or while a pending write's data phase is outstanding: the write is dropped and the outputs take their reset values.
- HBURST and HTRANS=SEQ: no burst-boundary checks. SEQ beats are decoded exactly like NONSEQ.

Test Plan:
- Reset preload, WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10. Read data phase has HREADYOUT=1 the same cycle, HRDATA=0xDEADBEEF, HRESP=0.
- Byte/half lane writes: word 0x00000000 at 0x20, byte write 0xAA at 0x22, half write 0x1234 at 0x20. Read of 0x20 returns 0x00AA1234.
- Wait states, WAIT_STATES=3: one read shows exactly 3 cycles of HREADYOUT=0, then 1. A 4-beat INCR4 from 0x40 completes in 16 cycles with correct words.
- ERROR response, MEM_BYTES=4096:
  - Read of 0x1000 gives HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, HRDATA unchanged.
  - Word read of 0x02 gives the same.
  - Write of 0x55 with HSIZE=3 to 0x30 leaves mem[0x30] unchanged.
- Pipelined read-after-write plus gating:
  - Write 0xCAFEF00D to 0x50, immediately followed by a read of 0x50; the read returns 0xCAFEF00D.
  - Transfers with HSEL=0, HREADY=0 or HTRANS=BUSY are ignored; memory is unchanged.
- Reset mid-operation, WAIT_STATES=2: assert HRESET during the WAIT of a write to 0x60. Next cycle HREADYOUT=1, HRESP=0, HRDATA=0; mem[0x60] keeps its old value.

Source files
------------

// File: rtl/ahb_lite_sram_slave_if.sv
// rtl/ahb_lite_sram_slave_if.sv - AHB-Lite bus bundle between a fetch master and the SRAM slave
//
// Address/control: HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HREADY (master side drives)
// Data:            HWDATA (master drives), HRDATA (slave drives)
// Response:        HREADYOUT, HRESP (slave drives)
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// rtl/ahb_lite_sram_slave.sv - AHB-Lite slave backed by a word-organised internal memory
//
// HCLK    : clock, all state on rising edge
// HRESET  : synchronous active-high reset (memory contents kept)
// bus     : AHB-Lite slave modport (HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HREADY in,
//           HRDATA/HREADYOUT/HRESP out)
// Beats are handled individually; HBURST and SEQ/NONSEQ distinction are ignored.
module ahb_lite_sram_slave #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_lite_sram_slave_if.slave  bus
);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WAW   = (AW > 2) ? AW - 2 : 1;
  localparam int WORDS = 1 << WAW;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t         state, state_n;
  logic [3:0]     wcnt, wcnt_n;
  logic [WAW-1:0] widx_q;
  logic [1:0]     lane_q;
  logic [1:0]     size_q;
  logic           write_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [WORDS];

  logic           can_accept;
  logic           accept;
  logic           bad_xfer;
  logic           do_read;
  logic           do_write;
  logic [3:0]     be;
  logic           unused_bits;

  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

  // Only sample a new address phase in cycles where this slave is itself ready,
  // so a misbehaving HREADY cannot overwrite the transfer held in WAIT/ERR1.
  assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept     = can_accept & bus.HSEL & bus.HREADY & bus.HTRANS[1];

  assign bad_xfer = (bus.HADDR >= 32'(MEM_BYTES))
                  | (bus.HSIZE > 3'd2)
                  | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                  | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'd0));

  assign do_read  = (state == S_DATA) & ~write_q;
  // A reset edge arriving during the data phase must drop the write.
  assign do_write = (state == S_DATA) & write_q & ~HRESET;

  // Read data is combinational from the registered address during DATA and
  // held from the last completed read otherwise.
  assign bus.HRDATA = do_read ? mem[widx_q] : rdata_q;

  always_comb begin
    state_n       = state;
    wcnt_n        = wcnt;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    case (state)
      S_WAIT: begin
        bus.HREADYOUT = 1'b0;
        if (wcnt == 4'd0) state_n = S_DATA;
        else              wcnt_n  = wcnt - 4'd1;
      end
      S_ERR1: begin
        bus.HREADYOUT = 1'b0;
        bus.HRESP     = 1'b1;
        state_n       = S_ERR2;
      end
      S_ERR2: bus.HRESP = 1'b1;
      default: ;
    endcase
    if (accept) begin
      if (bad_xfer) begin
        state_n = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_n = S_WAIT;
        wcnt_n  = WS_M1;
      end else begin
        state_n = S_DATA;
      end
    end else if (can_accept) begin
      state_n = S_IDLE;
    end
  end

  always_comb begin
    be = 4'b1111;
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      wcnt    <= 4'd0;
      rdata_q <= 32'd0;
      widx_q  <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (do_read) rdata_q <= mem[widx_q];
      if (accept) begin
        widx_q  <= bus.HADDR[WAW+1:2];
        lane_q  <= bus.HADDR[1:0];
        size_q  <= bus.HSIZE[1:0];
        write_q <= bus.HWRITE;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb/tb_ahb_lite_sram_slave.sv - self-checking bench for ahb_lite_sram_slave
//
// Three instances (WAIT_STATES 0, 3, 2) share one driven bus; dut_sel routes HSEL
// and picks which response is observed. Each slave sees HREADY = its own HREADYOUT.
module tb_ahb_lite_sram_slave;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [1:0]  trans;
  } xfer_t;

  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_kill;
  int          dut_sel;

  ahb_lite_sram_slave_if b0 ();
  ahb_lite_sram_slave_if b1 ();
  ahb_lite_sram_slave_if b2 ();

  assign b0.HSEL = hsel && (dut_sel == 0);
  assign b1.HSEL = hsel && (dut_sel == 1);
  assign b2.HSEL = hsel && (dut_sel == 2);
  assign b0.HADDR = haddr;   assign b1.HADDR = haddr;   assign b2.HADDR = haddr;
  assign b0.HTRANS = htrans; assign b1.HTRANS = htrans; assign b2.HTRANS = htrans;
  assign b0.HWRITE = hwrite; assign b1.HWRITE = hwrite; assign b2.HWRITE = hwrite;
  assign b0.HSIZE = hsize;   assign b1.HSIZE = hsize;   assign b2.HSIZE = hsize;
  assign b0.HBURST = hburst; assign b1.HBURST = hburst; assign b2.HBURST = hburst;
  assign b0.HWDATA = hwdata; assign b1.HWDATA = hwdata; assign b2.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT & ~hready_kill;
  assign b1.HREADY = b1.HREADYOUT & ~hready_kill;
  assign b2.HREADY = b2.HREADYOUT & ~hready_kill;

  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(0)) u0 (.HCLK(clk), .HRESET(rst), .bus(b0));
  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(3)) u1 (.HCLK(clk), .HRESET(rst), .bus(b1));
  ahb_lite_sram_slave #(.MEM_BYTES(4096), .WAIT_STATES(2)) u2 (.HCLK(clk), .HRESET(rst), .bus(b2));

  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_resp;
  always_comb begin
    o_rdata = b0.HRDATA; o_ready = b0.HREADYOUT; o_resp = b0.HRESP;
    if (dut_sel == 1) begin o_rdata = b1.HRDATA; o_ready = b1.HREADYOUT; o_resp = b1.HRESP; end
    if (dut_sel == 2) begin o_rdata = b2.HRDATA; o_ready = b2.HREADYOUT; o_resp = b2.HRESP; end
  end

  // Reference model: byte-addressed memory per instance plus the last read word.
  logic [7:0]  ref_mem [3][4096];
  bit          known   [3][4096];
  logic [31:0] last_rdata [3];
  int          ws_of [3] = '{0, 3, 2};
  xfer_t       xq[$];
  logic [31:0] obs_last;
  int          total = 0;
  int          bad = 0;

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    if (a >= 32'd4096 || s > 3'd2) return 1'b1;
    return (a % (32'd1 << s)) != 32'd0;
  endfunction

  function automatic logic [31:0] model_word(int d, logic [31:0] a);
    int base = int'(a) & ~3;
    return {ref_mem[d][base+3], ref_mem[d][base+2], ref_mem[d][base+1], ref_mem[d][base]};
  endfunction

  function automatic bit word_known(int d, logic [31:0] a);
    int base = int'(a) & ~3;
    return known[d][base] && known[d][base+1] && known[d][base+2] && known[d][base+3];
  endfunction

  task automatic model_write(int d, logic [31:0] a, logic [2:0] s, logic [31:0] w);
    for (int i = 0; i < (1 << s); i++) begin
      int ba = int'(a) + i;
      ref_mem[d][ba] = w[8*(ba % 4) +: 8];
      known[d][ba]   = 1'b1;
    end
  endtask

  // Value is given right-aligned; sub-word data is moved onto its byte lanes here.
  task automatic push(logic [31:0] a, bit wr, logic [2:0] s, logic [31:0] v, logic [1:0] t);
    xfer_t x;
    x.addr = a; x.wr = wr; x.size = s; x.trans = t;
    x.wdata = (s < 3'd2) ? (v << (8 * a[1:0])) : v;
    xq.push_back(x);
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2; haddr = 32'd0; hwdata = 32'd0;
  endtask

  // Pipelined master: drains xq, checks every data-phase cycle against the model.
  task automatic run(output int cycles, output int lows);
    xfer_t dp;
    bit    dp_v = 1'b0;
    int    dp_age = 0;
    int    d = dut_sel;
    cycles = 0;
    lows = 0;
    while ((xq.size() > 0 || dp_v) && cycles < 1000) begin
      if (xq.size() > 0) begin
        hsel = 1'b1; haddr = xq[0].addr; htrans = xq[0].trans;
        hwrite = xq[0].wr; hsize = xq[0].size;
      end else begin
        hsel = 1'b0; htrans = 2'd0;
      end
      hwdata = dp_v ? dp.wdata : 32'd0;
      @(negedge clk);
      if (!o_ready) lows++;
      if (dp_v) begin
        bit e;
        bit want_ready;
        e = is_err(dp.addr, dp.size);
        want_ready = e ? (dp_age == 1) : (dp_age == ws_of[d]);
        total++;
        if (o_resp !== e) begin
          bad++;
          $display("FAIL hresp dut=%0d addr=%h age=%0d got=%b want=%b", d, dp.addr, dp_age, o_resp, e);
        end
        total++;
        if (o_ready !== want_ready) begin
          bad++;
          $display("FAIL hreadyout dut=%0d addr=%h age=%0d got=%b want=%b", d, dp.addr, dp_age, o_ready, want_ready);
        end
        if (e || !o_ready) begin
          total++;
          if (o_rdata !== last_rdata[d]) begin
            bad++;
            $display("FAIL hrdata_hold dut=%0d addr=%h got=%h want=%h", d, dp.addr, o_rdata, last_rdata[d]);
          end
        end else if (!dp.wr && word_known(d, dp.addr)) begin
          total++;
          if (o_rdata !== model_word(d, dp.addr)) begin
            bad++;
            $display("FAIL hrdata dut=%0d addr=%h got=%h want=%h", d, dp.addr, o_rdata, model_word(d, dp.addr));
          end
          obs_last = o_rdata;
          last_rdata[d] = model_word(d, dp.addr);
        end
        if (o_ready && !e && dp.wr) model_write(d, dp.addr, dp.size, dp.wdata);
        if (!o_ready) dp_age++;
      end
      if (o_ready) begin
        if (xq.size() > 0) begin
          dp = xq.pop_front(); dp_v = 1'b1; dp_age = 0;
        end else begin
          dp_v = 1'b0;
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    total++;
    if (cycles >= 1000) begin
      bad++;
      $display("FAIL run_timeout dut=%0d got=%0d cycles want<1000", d, cycles);
      xq.delete();
    end
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      dut_sel = d;
      last_rdata[d] = 32'd0;
      @(negedge clk);
      total++;
      if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'd0) begin
        bad++;
        $display("FAIL reset_state dut=%0d got=%b/%b/%h want=1/0/00000000", d, o_ready, o_resp, o_rdata);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    int c, l;
    dut_sel = 0;
    push(32'h10, 1, 3'd2, 32'hDEADBEEF, 2'd2);
    push(32'h10, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (c !== 3 || l !== 0) begin
      bad++;
      $display("FAIL preload_timing got cycles=%0d lows=%0d want cycles=3 lows=0", c, l);
    end
    total++;
    if (obs_last !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL preload_data got=%h want=deadbeef", obs_last);
    end
  endtask

  task automatic test_lanes();
    int c, l;
    dut_sel = 0;
    push(32'h20, 1, 3'd2, 32'h0, 2'd2);
    push(32'h22, 1, 3'd0, 32'hAA, 2'd2);
    push(32'h20, 1, 3'd1, 32'h1234, 2'd2);
    push(32'h20, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (obs_last !== 32'h00AA1234) begin
      bad++;
      $display("FAIL lanes got=%h want=00aa1234", obs_last);
    end
  endtask

  task automatic test_wait_states();
    int c, l;
    dut_sel = 1;
    for (int i = 0; i < 4; i++) push(32'h40 + 4 * i, 1, 3'd2, 32'h4000_0000 + i, 2'd2);
    run(c, l);
    push(32'h40, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (l !== 3) begin
      bad++;
      $display("FAIL wait_single got lows=%0d want=3", l);
    end
    hburst = 3'b011;
    push(32'h40, 0, 3'd2, 32'h0, 2'd2);
    for (int i = 1; i < 4; i++) push(32'h40 + 4 * i, 0, 3'd2, 32'h0, 2'd3);
    run(c, l);
    hburst = 3'd0;
    total++;
    if (c - 1 !== 16) begin
      bad++;
      $display("FAIL incr4_cycles got=%0d want=16", c - 1);
    end
    total++;
    if (obs_last !== 32'h4000_0003) begin
      bad++;
      $display("FAIL incr4_last got=%h want=40000003", obs_last);
    end
  endtask

  task automatic test_error();
    int c, l;
    dut_sel = 0;
    push(32'h30, 1, 3'd2, 32'h30303030, 2'd2);
    push(32'h10, 0, 3'd2, 32'h0, 2'd2);
    push(32'h1000, 0, 3'd2, 32'h0, 2'd2);
    push(32'h02, 0, 3'd2, 32'h0, 2'd2);
    push(32'h30, 1, 3'd3, 32'h55, 2'd2);
    push(32'h31, 1, 3'd1, 32'hFFFF, 2'd2);
    push(32'h30, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (obs_last !== 32'h30303030) begin
      bad++;
      $display("FAIL error_no_write got=%h want=30303030", obs_last);
    end
  endtask

  task automatic test_back_to_back_raw();
    int c, l;
    dut_sel = 0;
    push(32'h50, 1, 3'd2, 32'hCAFEF00D, 2'd2);
    push(32'h50, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (obs_last !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL raw got=%h want=cafef00d", obs_last);
    end
  endtask

  task automatic test_gating();
    int c, l;
    dut_sel = 0;
    push(32'h70, 1, 3'd2, 32'h70707070, 2'd2);
    run(c, l);
    for (int k = 0; k < 3; k++) begin
      hsel = (k != 0); haddr = 32'h70; hwrite = 1'b1; hsize = 3'd2;
      htrans = (k == 2) ? 2'd1 : 2'd2;
      hready_kill = (k == 1);
      @(posedge clk); #1;
      bus_idle();
      hready_kill = 1'b0;
      hwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      total++;
      if (o_ready !== 1'b1 || o_resp !== 1'b0) begin
        bad++;
        $display("FAIL gating_idle kind=%0d got=%b/%b want=1/0", k, o_ready, o_resp);
      end
      @(posedge clk); #1;
    end
    push(32'h70, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (obs_last !== 32'h70707070) begin
      bad++;
      $display("FAIL gating_mem got=%h want=70707070", obs_last);
    end
  endtask

  task automatic test_reset_mid();
    int c, l;
    dut_sel = 2;
    push(32'h60, 1, 3'd2, 32'h11111111, 2'd2);
    run(c, l);
    hsel = 1'b1; haddr = 32'h60; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hBADBADBA;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_wait got=%b want=0", o_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) last_rdata[d] = 32'd0;
    @(negedge clk);
    total++;
    if (o_ready !== 1'b1 || o_resp !== 1'b0 || o_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid_out got=%b/%b/%h want=1/0/00000000", o_ready, o_resp, o_rdata);
    end
    @(posedge clk); #1;
    push(32'h60, 0, 3'd2, 32'h0, 2'd2);
    run(c, l);
    total++;
    if (obs_last !== 32'h11111111) begin
      bad++;
      $display("FAIL reset_mid_mem got=%h want=11111111", obs_last);
    end
  endtask

  task automatic test_random();
    int c, l;
    for (int d = 0; d < 3; d++) begin
      dut_sel = d;
      for (int i = 0; i < 16; i++) push(32'h200 + 4 * i, 1, 3'd2, $urandom, 2'd2);
      run(c, l);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        logic [2:0]  s;
        int          r;
        a = 32'h200 + $urandom_range(0, 63);
        s = 3'($urandom_range(0, 2));
        r = $urandom_range(0, 15);
        if (r > 3) a = a & ~((32'd1 << s) - 32'd1);
        if (r == 0) a = a + 32'h1000;
        if (r == 1) s = 3'($urandom_range(3, 7));
        push(a, $urandom_range(0, 1), s, $urandom, $urandom_range(0, 1) ? 2'd2 : 2'd3);
      end
      run(c, l);
    end
  endtask

  initial begin
    hready_kill = 1'b0;
    hburst = 3'd0;
    dut_sel = 0;
    obs_last = 32'd0;
    bus_idle();
    test_reset();
    test_preload();
    test_lanes();
    test_wait_states();
    test_error();
    test_back_to_back_raw();
    test_gating();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
